// File: rtl/interrupt_controller_n.sv
// Interrupt controller for the 8051 core: edge/level capture, two-level priority
// arbitration, in-service tracking with high-over-low preemption and RETI unwinding.
module interrupt_controller_n #(
    parameter int         NUM_SRC    = 5,
    parameter logic [7:0] VEC_BASE   = 8'h03,
    parameter logic [7:0] VEC_STRIDE = 8'h08
) (
    input  logic               clock_i,
    input  logic               reset_i,
    input  logic               int_en_i,
    input  logic [NUM_SRC-1:0] src_req_i,
    input  logic [NUM_SRC-1:0] src_mask_i,
    input  logic [NUM_SRC-1:0] src_prio_i,
    input  logic [NUM_SRC-1:0] src_edge_i,
    input  logic               int_ack_i,
    input  logic               int_reti_i,
    output logic               int_o,
    output logic [7:0]         int_vec_o,
    output logic [NUM_SRC-1:0] int_sel_o,
    output logic [NUM_SRC-1:0] pending_o,
    output logic [1:0]         in_service_o
);

    logic [NUM_SRC-1:0] src_prev_q, src_prev_d;
    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic               int_q, int_d;
    logic [7:0]         int_vec_q, int_vec_d;
    logic [NUM_SRC-1:0] int_sel_q, int_sel_d;
    logic [1:0]         in_service_q, in_service_d;

    logic [NUM_SRC-1:0] new_edge;
    logic [NUM_SRC-1:0] req;
    logic [NUM_SRC-1:0] elig;
    logic [NUM_SRC-1:0] elig_hi;
    logic [NUM_SRC-1:0] elig_lo;
    logic [NUM_SRC-1:0] grp;
    logic [NUM_SRC-1:0] win_oh;
    logic               win_hi;
    logic               found;
    logic               allowed;
    logic               ack_fire;
    logic [7:0]         win_vec;
    logic [7:0]         vec_tab [NUM_SRC];

    // Vector table is constant; the multiply wraps modulo 256 by construction.
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_vec
        assign vec_tab[gi] = VEC_BASE + VEC_STRIDE * 8'(gi);
    end

    always_comb begin
        new_edge = src_edge_i & src_req_i & ~src_prev_q;
        req      = (src_edge_i & pending_q) | (~src_edge_i & src_req_i);
        elig     = req & src_mask_i & {NUM_SRC{int_en_i}};
        elig_hi  = elig & src_prio_i;
        elig_lo  = elig & ~src_prio_i;
        win_hi   = |elig_hi;
        grp      = win_hi ? elig_hi : elig_lo;

        win_oh  = '0;
        win_vec = 8'h00;
        found   = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grp[i] && !found) begin
                win_oh[i] = 1'b1;
                win_vec   = vec_tab[i];
                found     = 1'b1;
            end
        end

        // A running high-level ISR blocks everything; a low-level one admits only high.
        allowed = found & ~in_service_q[1] & (~in_service_q[0] | win_hi);
        ack_fire = int_ack_i & int_q;

        src_prev_d = src_req_i;
        // A fresh edge in the ack cycle is OR-ed last so it survives the clear.
        pending_d  = (pending_q & ~(ack_fire ? (int_sel_q & src_edge_i) : '0)) | new_edge;

        in_service_d = in_service_q;
        if (int_reti_i) begin
            if (in_service_d[1]) in_service_d[1] = 1'b0;
            else                 in_service_d[0] = 1'b0;
        end
        if (ack_fire) begin
            if (|(int_sel_q & src_prio_i)) in_service_d[1] = 1'b1;
            else                           in_service_d[0] = 1'b1;
        end

        int_d     = allowed & ~int_ack_i;
        int_vec_d = allowed ? win_vec : 8'h00;
        int_sel_d = allowed ? win_oh : '0;
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            src_prev_q   <= '0;
            pending_q    <= '0;
            int_q        <= 1'b0;
            int_vec_q    <= 8'h00;
            int_sel_q    <= '0;
            in_service_q <= 2'b00;
        end else begin
            src_prev_q   <= src_prev_d;
            pending_q    <= pending_d;
            int_q        <= int_d;
            int_vec_q    <= int_vec_d;
            int_sel_q    <= int_sel_d;
            in_service_q <= in_service_d;
        end
    end

    assign int_o        = int_q;
    assign int_vec_o    = int_vec_q;
    assign int_sel_o    = int_sel_q;
    assign pending_o    = pending_q;
    assign in_service_o = in_service_q;

endmodule

// File: tb/tb_interrupt_controller_n.sv
// Bench for interrupt_controller_n: directed scenarios with literal expectations plus
// randomized traffic, all compared each cycle against a per-source behavioural model.
module tb_interrupt_controller_n;

    localparam int N  = 5;
    localparam int VB = 8'h03;
    localparam int VS = 8'h08;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic         reset, int_en, int_ack, int_reti;
    logic [N-1:0] src_req, src_mask, src_prio, src_edge;
    logic         irq;
    logic [7:0]   vec;
    logic [N-1:0] sel, pend;
    logic [1:0]   insvc;

    interrupt_controller_n #(
        .NUM_SRC(N), .VEC_BASE(8'h03), .VEC_STRIDE(8'h08)
    ) dut (
        .clock_i(clock), .reset_i(reset), .int_en_i(int_en),
        .src_req_i(src_req), .src_mask_i(src_mask), .src_prio_i(src_prio),
        .src_edge_i(src_edge), .int_ack_i(int_ack), .int_reti_i(int_reti),
        .int_o(irq), .int_vec_o(vec), .int_sel_o(sel), .pending_o(pend),
        .in_service_o(insvc)
    );

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: per-source flags, winner as an index, service levels as two flags.
    bit [N-1:0] m_prev = '0;
    bit [N-1:0] m_pend = '0;
    bit         m_int  = 1'b0;
    int         m_vec  = 0;
    int         m_sel  = -1;
    bit         m_hi   = 1'b0;
    bit         m_lo   = 1'b0;

    function automatic bit eligible(int i);
        return int_en && src_mask[i] && (src_edge[i] ? m_pend[i] : src_req[i]);
    endfunction

    always @(posedge clock) begin : model
        int         w;
        bit         ok, ack, nh, nl;
        bit [N-1:0] np;
        if (reset) begin
            m_prev <= '0; m_pend <= '0; m_int <= 1'b0; m_vec <= 0;
            m_sel <= -1; m_hi <= 1'b0; m_lo <= 1'b0;
        end else begin
            ack = int_ack && m_int;
            w = -1;
            for (int i = 0; i < N; i++) if (w < 0 && src_prio[i] && eligible(i)) w = i;
            for (int i = 0; i < N; i++) if (w < 0 && !src_prio[i] && eligible(i)) w = i;
            ok = (w >= 0) && !m_hi && (!m_lo || src_prio[w]);
            np = m_pend;
            for (int i = 0; i < N; i++) begin
                if (ack && m_sel == i && src_edge[i]) np[i] = 1'b0;
                if (src_edge[i] && src_req[i] && !m_prev[i]) np[i] = 1'b1;
            end
            nh = m_hi; nl = m_lo;
            if (int_reti) begin
                if (nh) nh = 1'b0;
                else    nl = 1'b0;
            end
            if (ack && m_sel >= 0) begin
                if (src_prio[m_sel]) nh = 1'b1;
                else                 nl = 1'b1;
                $display("ack: source %0d vector %02h level %s", m_sel, m_vec[7:0],
                         src_prio[m_sel] ? "high" : "low");
            end
            m_prev <= src_req;
            m_pend <= np;
            m_hi   <= nh;
            m_lo   <= nl;
            m_int  <= ok && !int_ack;
            m_vec  <= ok ? (VB + w * VS) % 256 : 0;
            m_sel  <= ok ? w : -1;
        end
    end

    always @(negedge clock) begin
        if (cmp_en) begin
            chk("int", {31'b0, irq}, {31'b0, m_int});
            chk("int_vec", {24'b0, vec}, m_vec);
            chk("int_sel", {27'b0, sel}, (m_sel >= 0) ? (32'd1 << m_sel) : 32'd0);
            chk("pending", {27'b0, pend}, {27'b0, m_pend});
            chk("in_service", {30'b0, insvc}, {30'b0, m_hi, m_lo});
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; src_req = '0; int_ack = 1'b0; int_reti = 1'b0;
        src_mask = '1; src_prio = '0; src_edge = '1; int_en = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; int_en = 1'b1; src_req = '0; src_mask = '1;
        src_prio = '0; src_edge = '1; int_ack = 1'b0; int_reti = 1'b0;
        tick(); tick();
        cmp_en = 1'b1;
        chk("reset_int", {31'b0, irq}, 0);
        chk("reset_vec", {24'b0, vec}, 0);
        chk("reset_sel", {27'b0, sel}, 0);
        chk("reset_insvc", {30'b0, insvc}, 0);
        reset = 1'b0;

        $display("test 1: src2 low edge");
        src_req = 5'b00100; tick(); src_req = '0; tick();
        chk("t1_int", {31'b0, irq}, 1);
        chk("t1_vec", {24'b0, vec}, 8'h13);
        chk("t1_pend", {27'b0, pend}, 5'b00100);
        int_ack = 1'b1; tick(); int_ack = 1'b0;
        chk("t1_ack_int", {31'b0, irq}, 0);
        chk("t1_ack_pend", {27'b0, pend}, 0);
        chk("t1_ack_insvc", {30'b0, insvc}, 2'b01);

        $display("test 2: high beats low, then low after RETI");
        do_reset();
        src_prio = 5'b00010; src_req = 5'b00011; tick(); src_req = '0; tick();
        chk("t2_vec_hi", {24'b0, vec}, 8'h0B);
        int_ack = 1'b1; tick(); int_ack = 1'b0;
        chk("t2_insvc", {30'b0, insvc}, 2'b10);
        int_reti = 1'b1; tick(); int_reti = 1'b0; tick();
        chk("t2_int_lo", {31'b0, irq}, 1);
        chk("t2_vec_lo", {24'b0, vec}, 8'h03);

        $display("test 3: preemption of a low-level ISR");
        do_reset();
        src_req = 5'b00100; tick(); src_req = '0; tick();
        int_ack = 1'b1; tick(); int_ack = 1'b0;
        chk("t3_insvc_lo", {30'b0, insvc}, 2'b01);
        src_req = 5'b00010; tick(); src_req = '0; tick();
        chk("t3_blocked", {31'b0, irq}, 0);
        src_prio = 5'b01000; src_req = 5'b01000; tick(); src_req = '0; tick();
        chk("t3_int_hi", {31'b0, irq}, 1);
        chk("t3_vec_hi", {24'b0, vec}, 8'h1B);
        int_ack = 1'b1; tick(); int_ack = 1'b0;
        chk("t3_insvc_both", {30'b0, insvc}, 2'b11);

        $display("test 4: level source held high");
        do_reset();
        src_edge = 5'b01111; src_req = 5'b10000; tick();
        chk("t4_int", {31'b0, irq}, 1);
        chk("t4_vec", {24'b0, vec}, 8'h23);
        int_ack = 1'b1; tick(); int_ack = 1'b0;
        chk("t4_ack_int", {31'b0, irq}, 0);
        tick();
        chk("t4_held_int", {31'b0, irq}, 0);
        int_reti = 1'b1; tick(); int_reti = 1'b0; tick();
        chk("t4_rereq_int", {31'b0, irq}, 1);
        chk("t4_rereq_vec", {24'b0, vec}, 8'h23);

        $display("test 5: masked edge stays pending");
        do_reset();
        src_mask = 5'b11110; src_req = 5'b00001; tick(); src_req = '0; tick();
        chk("t5_pend", {27'b0, pend}, 5'b00001);
        chk("t5_masked_int", {31'b0, irq}, 0);
        src_mask = '1; tick();
        chk("t5_int", {31'b0, irq}, 1);
        chk("t5_vec", {24'b0, vec}, 8'h03);

        $display("test 6: reset mid-service");
        do_reset();
        src_req = 5'b00001; tick(); src_req = '0; tick();
        int_ack = 1'b1; tick(); int_ack = 1'b0;
        src_prio = 5'b00100; src_req = 5'b00100; tick(); src_req = '0; tick();
        chk("t6_vec", {24'b0, vec}, 8'h13);
        int_ack = 1'b1; tick(); int_ack = 1'b0;
        src_req = 5'b10010; tick(); src_req = '0;
        chk("t6_pre_insvc", {30'b0, insvc}, 2'b11);
        chk("t6_pre_pend", {27'b0, pend}, 5'b10010);
        reset = 1'b1; tick(); reset = 1'b0;
        chk("t6_int", {31'b0, irq}, 0);
        chk("t6_insvc", {30'b0, insvc}, 0);
        chk("t6_pend", {27'b0, pend}, 0);
        chk("t6_sel", {27'b0, sel}, 0);

        $display("random traffic");
        for (int c = 0; c < 3000; c++) begin
            if (c % 200 == 0) begin
                src_prio = 5'($urandom);
                src_edge = 5'($urandom);
                src_mask = 5'($urandom) | 5'($urandom);
            end
            if ($urandom_range(0, 49) == 0) src_mask = 5'($urandom);
            int_en   = ($urandom_range(0, 9) != 0);
            src_req  = 5'($urandom) & 5'($urandom) & 5'($urandom);
            int_ack  = m_int ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
            int_reti = ($urandom_range(0, 11) == 0);
            reset    = ($urandom_range(0, 499) == 0);
            tick();
        end
        reset = 1'b0; int_ack = 1'b0; int_reti = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
